// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives instruction memory and PC updates, and feeds the IF/ID register.
// Latency: an acked word reaches IF/ID on the clock edge of its ack, or on the edge that ends a stall.
// Backpressure: a decode stall holds IF/ID; a word acked during a stall is parked in HOLD with no new request.
//
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   pc                        : current PC from the program counter register
//   PCWrite, PCWriteValue     : combinational PC load enable and next-PC value
//   imem_req, imem_addr       : memory request; held stable until imem_ack
//   imem_ack, imem_rdata      : memory response; data valid in the ack cycle
//   stall, flush, redirect_target : decode stall and control redirect
//   ifid_valid, ifid_instr, ifid_pc4 : IF/ID pipeline register contents
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        PCWrite,
    output logic [31:0] PCWriteValue,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;
    logic [31:0] pc_plus4;
    logic        load_fetch;
    logic        load_buf;
    logic        capture;

    // Natural 32-bit wrap gives the modulo-2^32 PC increment.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        state_nxt    = state;
        PCWrite      = 1'b0;
        PCWriteValue = 32'h0;
        imem_req     = 1'b0;
        imem_addr    = 32'h0;
        load_fetch   = 1'b0;
        load_buf     = 1'b0;
        capture      = 1'b0;
        if (!rst) begin
            case (state)
                S_REQ: begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                    if (flush) begin
                        // Redirect now; an unacked request must still be drained
                        // at its original address before the new fetch starts.
                        PCWrite      = 1'b1;
                        PCWriteValue = redirect_target;
                        if (!imem_ack) begin
                            state_nxt = S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            capture   = 1'b1;
                            state_nxt = S_HOLD;
                        end else begin
                            load_fetch   = 1'b1;
                            PCWrite      = 1'b1;
                            PCWriteValue = pc_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        PCWrite      = 1'b1;
                        PCWriteValue = redirect_target;
                        state_nxt    = S_REQ;
                    end else if (!stall) begin
                        load_buf     = 1'b1;
                        PCWrite      = 1'b1;
                        PCWriteValue = buf_pc4;
                        state_nxt    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = addr_q;
                    // A further redirect while draining overrides the earlier one.
                    if (flush) begin
                        PCWrite      = 1'b1;
                        PCWriteValue = redirect_target;
                    end
                    if (imem_ack) begin
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            addr_q     <= 32'h0;
            buf_instr  <= 32'h0;
            buf_pc4    <= 32'h0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'h0;
        end else begin
            state <= state_nxt;
            // Track the live request address so DRAIN can keep presenting it
            // after the PC has already moved to the redirect target.
            if (state == S_REQ) begin
                addr_q <= pc;
            end
            if (capture) begin
                buf_instr <= imem_rdata;
                buf_pc4   <= pc_plus4;
            end
            if (flush) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end else if (stall) begin
                ifid_valid <= ifid_valid;
            end else if (load_fetch) begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_rdata;
                ifid_pc4   <= pc_plus4;
            end else if (load_buf) begin
                ifid_valid <= 1'b1;
                ifid_instr <= buf_instr;
                ifid_pc4   <= buf_pc4;
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word loaded into IF/ID on reset and on flush.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc  input  32  current PC value from the program counter register.
REQ-005 PCWrite  output  1  PC load enable to the program counter.
REQ-006 PCWriteValue  output  32  next PC value; meaningful only when PCWrite=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  instruction memory byte address.
REQ-009 imem_ack  input  1  memory response valid; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 stall  input  1  decode stall; IF/ID must hold its contents.
REQ-012 flush  input  1  control redirect (taken branch/jump); discard in-flight fetch.
REQ-013 redirect_target  input  32  redirect PC; valid when flush=1.
REQ-014 ifid_valid  output  1  IF/ID holds a live instruction.
REQ-015 ifid_instr  output  32  IF/ID instruction word.
REQ-016 ifid_pc4  output  32  IF/ID PC+4 of that instruction.

Function
REQ-017 The FSM shall have exactly three states: REQ (request outstanding), HOLD (fetched word buffered during a stall), DRAIN (discarding a fetch squashed by flush).
REQ-018 In REQ: imem_req=1 and imem_addr=pc; in REQ the address shall also be latched into addr_q each cycle.
REQ-019 In DRAIN: imem_req=1 and imem_addr=addr_q (address held stable until ack); in HOLD: imem_req=0.
REQ-020 Memory handshake: once raised, imem_req and imem_addr shall stay constant until the cycle imem_ack=1, except on rst.
REQ-021 REQ, ack, flush=1: discard data; PCWrite=1, PCWriteValue=redirect_target; stay REQ.
REQ-022 REQ, ack, flush=0, stall=0: load IF/ID (valid=1, instr=imem_rdata, pc4=pc+4); PCWrite=1, PCWriteValue=pc+4; stay REQ.
REQ-023 REQ, ack, flush=0, stall=1: capture imem_rdata and pc+4 into buffer; PCWrite=0; go HOLD.
REQ-024 REQ, no ack, flush=1: PCWrite=1, PCWriteValue=redirect_target; go DRAIN.
REQ-025 REQ, no ack, flush=0: PCWrite=0; stay REQ.
REQ-026 HOLD, flush=1: discard buffer; PCWrite=1, PCWriteValue=redirect_target; go REQ.
REQ-027 HOLD, flush=0, stall=0: load IF/ID from buffer (valid=1); PCWrite=1, PCWriteValue=buffered pc4; go REQ.
REQ-028 HOLD, flush=0, stall=1: hold everything; PCWrite=0.
REQ-029 DRAIN, ack: discard data, go REQ; flush=1 in DRAIN (with or without ack) shall issue PCWrite=1, PCWriteValue=redirect_target (latest redirect wins).
REQ-030 IF/ID priority per cycle: flush (valid=0, instr=NOP_INSTR, pc4 unchanged) > stall (hold) > load per REQ-022/027 > bubble (valid=0, instr and pc4 unchanged).
REQ-031 PC+4 shall be computed modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-032 PCWrite and PCWriteValue shall be combinational from state and inputs; at most one PCWrite pulse per accepted instruction or redirect.

Reset
REQ-033 While rst=1: imem_req=0, PCWrite=0, imem_addr=0.
REQ-034 On posedge clk with rst=1: state=REQ, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0, addr_q=0, buffer cleared.
REQ-035 Reset mid-operation shall abandon any outstanding request with no ack wait; the instruction memory shares this reset.

Verification
REQ-036 Reset, pc=0, ack 1 cycle after req with rdata=32'h2008_0005 -> imem_addr=0, PCWriteValue=4, next cycle ifid_valid=1, ifid_instr=32'h2008_0005, ifid_pc4=4.
REQ-037 ack with stall=1 for 3 cycles, pc=32'h40 -> HOLD, imem_req=0, PCWrite=0 for 3 cycles; stall drop -> IF/ID loads word, ifid_pc4=32'h44, PCWriteValue=32'h44.
REQ-038 flush=1, redirect_target=32'h100 while request at 32'h40 pending -> PCWrite with 32'h100, DRAIN keeps imem_addr=32'h40 until ack, ack data never reaches IF/ID, next request at 32'h100.
REQ-039 flush and stall both 1 with valid IF/ID -> ifid_valid=0, ifid_instr=NOP_INSTR next cycle.
REQ-040 pc=32'hFFFF_FFFC fetched -> PCWriteValue=0, ifid_pc4=0.
REQ-041 rst=1 asserted in HOLD and DRAIN -> imem_req=0 same cycle, ifid_valid=0 next cycle, state REQ after release.
